// File: rtl/meter_pkg.sv
// Shared constants and types for the parking meter command path.
package meter_pkg;

    localparam int TIME_W  = 14;
    localparam int NUM_BTN = 6;

    localparam logic [TIME_W-1:0] AMT_ADD1  = 14'd60;
    localparam logic [TIME_W-1:0] AMT_ADD2  = 14'd120;
    localparam logic [TIME_W-1:0] AMT_ADD3  = 14'd180;
    localparam logic [TIME_W-1:0] AMT_ADD4  = 14'd300;
    localparam logic [TIME_W-1:0] AMT_LOAD1 = 14'd15;
    localparam logic [TIME_W-1:0] AMT_LOAD2 = 14'd10;

    localparam logic OP_ADD  = 1'b0;
    localparam logic OP_LOAD = 1'b1;

    typedef enum logic [2:0] {
        BTN_ADD1 = 3'd0,
        BTN_ADD2 = 3'd1,
        BTN_ADD3 = 3'd2,
        BTN_ADD4 = 3'd3,
        BTN_RST1 = 3'd4,
        BTN_RST2 = 3'd5
    } btn_e;

    // Seconds added by an add button; load buttons have no add amount.
    function automatic logic [TIME_W-1:0] add_amount(input btn_e b);
        case (b)
            BTN_ADD1: add_amount = AMT_ADD1;
            BTN_ADD2: add_amount = AMT_ADD2;
            BTN_ADD3: add_amount = AMT_ADD3;
            BTN_ADD4: add_amount = AMT_ADD4;
            default:  add_amount = '0;
        endcase
    endfunction

endpackage

// File: rtl/btn_sync_edge.sv
// Two-flop synchroniser for one raw button, plus a delay flop for rising-edge detect.
module btn_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic level,
    output logic rise
);

    logic s1, s2, s3;

    always_ff @(posedge clk) begin
        if (!rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= btn;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign level = s2;
    assign rise  = s2 & ~s3;

endmodule

// File: rtl/meter_cmd_arbiter.sv
// Turns six raw meter buttons into one prioritised, auto-repeating command stream
// for the time-remaining counter over a valid/ready handshake.
module meter_cmd_arbiter
    import meter_pkg::*;
#(
    parameter int HOLD_CYC   = 100,
    parameter int REPEAT_CYC = 20,
    parameter int CNT_W      = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              add1,
    input  logic              add2,
    input  logic              add3,
    input  logic              add4,
    input  logic              rst1,
    input  logic              rst2,
    input  logic              cmd_ready,
    output logic              cmd_valid,
    output logic              cmd_op,
    output logic [TIME_W-1:0] cmd_val,
    output logic              overrun
);

    logic [NUM_BTN-1:0] raw;
    logic [NUM_BTN-1:0] level;
    logic [NUM_BTN-1:0] rise;

    assign raw = {rst2, rst1, add4, add3, add2, add1};

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
        btn_sync_edge u_sync (
            .clk   (clk),
            .rst   (rst),
            .btn   (raw[i]),
            .level (level[i]),
            .rise  (rise[i])
        );
    end

    logic              edge_hit;
    logic              edge_op;
    logic [TIME_W-1:0] edge_val;

    // Fixed-priority pick among this cycle's edges; losers simply vanish.
    always_comb begin
        edge_hit = 1'b1;
        edge_op  = OP_ADD;
        edge_val = '0;
        if (rise[BTN_RST2]) begin
            edge_op  = OP_LOAD;
            edge_val = AMT_LOAD2;
        end else if (rise[BTN_RST1]) begin
            edge_op  = OP_LOAD;
            edge_val = AMT_LOAD1;
        end else if (rise[BTN_ADD4]) begin
            edge_val = AMT_ADD4;
        end else if (rise[BTN_ADD3]) begin
            edge_val = AMT_ADD3;
        end else if (rise[BTN_ADD2]) begin
            edge_val = AMT_ADD2;
        end else if (rise[BTN_ADD1]) begin
            edge_val = AMT_ADD1;
        end else begin
            edge_hit = 1'b0;
        end
    end

    logic track_vld;
    btn_e track_idx;

    always_comb begin
        track_vld = 1'b1;
        track_idx = BTN_ADD1;
        if (level[BTN_ADD4])      track_idx = BTN_ADD4;
        else if (level[BTN_ADD3]) track_idx = BTN_ADD3;
        else if (level[BTN_ADD2]) track_idx = BTN_ADD2;
        else if (level[BTN_ADD1]) track_idx = BTN_ADD1;
        else                      track_vld = 1'b0;
    end

    logic             prev_vld;
    btn_e             prev_idx;
    logic [CNT_W-1:0] hold_cnt;
    logic             repeating;
    logic             same_track;
    logic [CNT_W-1:0] rep_target;
    logic             rep_due;
    logic             rep_fire;

    assign same_track = track_vld && prev_vld && (prev_idx == track_idx) && !rise[track_idx];
    assign rep_target = repeating ? CNT_W'(REPEAT_CYC - 1) : CNT_W'(HOLD_CYC - 1);
    assign rep_due    = same_track && (hold_cnt == rep_target);
    // A held load button mutes repeats but the schedule keeps running underneath.
    assign rep_fire   = rep_due && !(level[BTN_RST1] || level[BTN_RST2]);

    always_ff @(posedge clk) begin
        if (!rst) begin
            prev_vld  <= 1'b0;
            prev_idx  <= BTN_ADD1;
            hold_cnt  <= '0;
            repeating <= 1'b0;
        end else begin
            prev_vld <= track_vld;
            prev_idx <= track_idx;
            if (!same_track) begin
                hold_cnt  <= '0;
                repeating <= 1'b0;
            end else if (rep_due) begin
                hold_cnt  <= '0;
                repeating <= 1'b1;
            end else if (hold_cnt != {CNT_W{1'b1}}) begin
                hold_cnt <= hold_cnt + 1'b1;
            end
        end
    end

    // A stalled command is never replaced; new edges only flag the loss.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cmd_valid <= 1'b0;
            cmd_op    <= OP_ADD;
            cmd_val   <= '0;
            overrun   <= 1'b0;
        end else if (cmd_valid && !cmd_ready) begin
            if (edge_hit) overrun <= 1'b1;
        end else if (edge_hit) begin
            cmd_valid <= 1'b1;
            cmd_op    <= edge_op;
            cmd_val   <= edge_val;
        end else if (rep_fire) begin
            cmd_valid <= 1'b1;
            cmd_op    <= OP_ADD;
            cmd_val   <= add_amount(track_idx);
        end else begin
            cmd_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_meter_cmd_arbiter.sv
// Directed bench for meter_cmd_arbiter: expected commands are queued as buttons are
// driven and checked (value and, where fixed, arrival cycle) as each handshake completes.
module tb_meter_cmd_arbiter;
    import meter_pkg::*;

    localparam logic [5:0] M_NONE = 6'b000000;
    localparam logic [5:0] M_ADD1 = 6'b000001;
    localparam logic [5:0] M_ADD2 = 6'b000010;
    localparam logic [5:0] M_ADD3 = 6'b000100;
    localparam logic [5:0] M_ADD4 = 6'b001000;
    localparam logic [5:0] M_RST1 = 6'b010000;
    localparam logic [5:0] M_RST2 = 6'b100000;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              add1 = 1'b0, add2 = 1'b0, add3 = 1'b0, add4 = 1'b0;
    logic              rst1 = 1'b0, rst2 = 1'b0;
    logic              cmd_ready = 1'b1;
    logic              cmd_valid;
    logic              cmd_op;
    logic [TIME_W-1:0] cmd_val;
    logic              overrun;

    typedef struct {
        logic              op;
        logic [TIME_W-1:0] val;
        int                cyc;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;

    meter_cmd_arbiter #(.HOLD_CYC(100), .REPEAT_CYC(20), .CNT_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .add1      (add1),
        .add2      (add2),
        .add3      (add3),
        .add4      (add4),
        .rst1      (rst1),
        .rst2      (rst2),
        .cmd_ready (cmd_ready),
        .cmd_valid (cmd_valid),
        .cmd_op    (cmd_op),
        .cmd_val   (cmd_val),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic [5:0] btns, input logic rdy, input int n);
        add1 = btns[0];
        add2 = btns[1];
        add3 = btns[2];
        add4 = btns[3];
        rst1 = btns[4];
        rst2 = btns[5];
        cmd_ready = rdy;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expectCmd(input logic op, input logic [TIME_W-1:0] val, input int at);
        exp_t e;
        e.op  = op;
        e.val = val;
        e.cyc = at;
        sb.push_back(e);
    endtask

    // Every completed handshake must match the oldest queued expectation.
    always @(negedge clk) begin
        if (rst && cmd_valid && cmd_ready) begin
            if (sb.size() == 0) begin
                checkOutput("unexpected_cmd_val", 32'(cmd_val), 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                checkOutput("cmd_op", 32'(cmd_op), 32'(e.op));
                checkOutput("cmd_val", 32'(cmd_val), 32'(e.val));
                if (e.cyc >= 0) checkOutput("cmd_cycle", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int p;
        int r;

        applyStimulus(M_NONE, 1'b1, 3);
        checkOutput("reset_valid", 32'(cmd_valid), 32'd0);
        checkOutput("reset_op", 32'(cmd_op), 32'd0);
        checkOutput("reset_val", 32'(cmd_val), 32'd0);
        checkOutput("reset_overrun", 32'(overrun), 32'd0);
        rst = 1'b1;
        applyStimulus(M_NONE, 1'b1, 2);

        $display("[TB] single add1 pulse");
        p = cyc;
        expectCmd(OP_ADD, AMT_ADD1, p + 3);
        applyStimulus(M_ADD1, 1'b1, 1);
        applyStimulus(M_NONE, 1'b1, 6);
        checkOutput("t1_valid_idle", 32'(cmd_valid), 32'd0);

        $display("[TB] add2/add3/add4 together");
        expectCmd(OP_ADD, AMT_ADD4, -1);
        applyStimulus(M_ADD2 | M_ADD3 | M_ADD4, 1'b1, 1);
        applyStimulus(M_NONE, 1'b1, 6);
        checkOutput("t2_overrun", 32'(overrun), 32'd0);

        $display("[TB] load priority");
        expectCmd(OP_LOAD, AMT_LOAD2, -1);
        applyStimulus(M_RST1 | M_RST2, 1'b1, 1);
        applyStimulus(M_NONE, 1'b1, 4);
        expectCmd(OP_LOAD, AMT_LOAD1, -1);
        applyStimulus(M_RST1 | M_ADD1, 1'b1, 1);
        applyStimulus(M_NONE, 1'b1, 6);
        checkOutput("t3_overrun", 32'(overrun), 32'd0);
        checkOutput("t3_pending", 32'(sb.size()), 32'd0);

        $display("[TB] stall and overrun");
        applyStimulus(M_NONE, 1'b0, 1);
        applyStimulus(M_ADD1, 1'b0, 1);
        applyStimulus(M_NONE, 1'b0, 3);
        checkOutput("t4_valid_stall", 32'(cmd_valid), 32'd1);
        checkOutput("t4_val_stall", 32'(cmd_val), 32'(AMT_ADD1));
        checkOutput("t4_overrun_before", 32'(overrun), 32'd0);
        applyStimulus(M_ADD3, 1'b0, 1);
        applyStimulus(M_NONE, 1'b0, 4);
        checkOutput("t4_valid_held", 32'(cmd_valid), 32'd1);
        checkOutput("t4_op_held", 32'(cmd_op), 32'(OP_ADD));
        checkOutput("t4_val_held", 32'(cmd_val), 32'(AMT_ADD1));
        checkOutput("t4_overrun_set", 32'(overrun), 32'd1);
        expectCmd(OP_ADD, AMT_ADD1, -1);
        applyStimulus(M_NONE, 1'b1, 1);
        checkOutput("t4_valid_drop", 32'(cmd_valid), 32'd0);
        applyStimulus(M_NONE, 1'b1, 4);

        $display("[TB] add4 held, auto-repeat");
        p = cyc;
        expectCmd(OP_ADD, AMT_ADD4, p + 3);
        for (int j = 0; j < 10; j++) expectCmd(OP_ADD, AMT_ADD4, p + 103 + 20 * j);
        applyStimulus(M_ADD4, 1'b1, 300);
        applyStimulus(M_NONE, 1'b1, 40);
        checkOutput("t5_pending", 32'(sb.size()), 32'd0);

        $display("[TB] reset during stall");
        applyStimulus(M_ADD4, 1'b0, 5);
        checkOutput("t6_valid_stall", 32'(cmd_valid), 32'd1);
        checkOutput("t6_val_stall", 32'(cmd_val), 32'(AMT_ADD4));
        rst = 1'b0;
        applyStimulus(M_ADD4, 1'b0, 1);
        checkOutput("t6_rst_valid", 32'(cmd_valid), 32'd0);
        checkOutput("t6_rst_op", 32'(cmd_op), 32'd0);
        checkOutput("t6_rst_val", 32'(cmd_val), 32'd0);
        checkOutput("t6_rst_overrun", 32'(overrun), 32'd0);
        rst = 1'b1;
        r = cyc;
        expectCmd(OP_ADD, AMT_ADD4, r + 3);
        expectCmd(OP_ADD, AMT_ADD4, r + 103);
        applyStimulus(M_ADD4, 1'b1, 105);
        applyStimulus(M_NONE, 1'b1, 30);

        for (int k = 0; k < 50 && sb.size() != 0; k++) @(posedge clk);
        checkOutput("sb_drain", 32'(sb.size()), 32'd0);
        checkOutput("final_overrun", 32'(overrun), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
